// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      StReq  = 2'b00,
      StWait = 2'b01,
      StHalt = 2'b10
   } state_e;

   localparam logic [4:0]  OPC_HALT      = 5'b00000;
   localparam logic [15:0] DEF_NOP_INSTR = 16'h0800;
   localparam logic [15:0] DEF_RESET_PC  = 16'h0000;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/done bus between fetch (master) and memory (slave).
interface fetch_if;

   logic [15:0] IMemAddr;
   logic        IMemRd;
   logic [15:0] IMemData;
   logic        IMemDone;

   modport master (output IMemAddr, output IMemRd, input IMemData, input IMemDone);
   modport slave  (input IMemAddr, input IMemRd, output IMemData, output IMemDone);

endinterface

// File: rtl/cla_16b.sv
// 16-bit carry-lookahead adder: 4-bit groups, lookahead carries between groups.
module cla_16b (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        cin_i,
   output logic [15:0] sum_o
);

   logic [14:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [2:0]  gg;
   logic [2:0]  gp;
   logic [3:0]  cg;

   always_comb begin
      g = a_i[14:0] & b_i[14:0];
      p = a_i ^ b_i;
      for (int k = 0; k < 3; k++) begin
         gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | ((&p[4*k+3 -: 2]) & g[4*k+1]) |
                 ((&p[4*k+3 -: 3]) & g[4*k]);
         gp[k] = &p[4*k +: 4];
      end
      cg[0] = cin_i;
      for (int k = 0; k < 3; k++) cg[k+1] = gg[k] | (gp[k] & cg[k]);
      for (int k = 0; k < 4; k++) begin
         c[4*k] = cg[k];
         for (int j = 0; j < 3; j++) c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
      sum_o = p ^ c;
   end

endmodule

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction and its PC+2 while decode stalls.
module fetch_skid (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_i,
   input  logic        rd_i,
   input  logic        clr_i,
   input  logic [15:0] data_i,
   input  logic [15:0] pc_plus2_i,
   output logic        full_o,
   output logic [15:0] data_o,
   output logic [15:0] pc_plus2_o
);

   logic        full_q;
   logic [15:0] data_q;
   logic [15:0] pc_plus2_q;

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         full_q <= 1'b0;
      end else if (wr_i) begin
         full_q <= 1'b1;
      end else if (rd_i) begin
         full_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_i) begin
         data_q     <= data_i;
         pc_plus2_q <= pc_plus2_i;
      end
   end

   assign full_o     = full_q;
   assign data_o     = data_q;
   assign pc_plus2_o = pc_plus2_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, drives imem over fetch_if, feeds decode.
// Define FETCH_PERF_CNT_EN to enable the memory-wait cycle counter on StallCycles.
module fetch
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [15:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] PC_Next,
   input  logic        Redirect,
   input  logic        Stall,
   fetch_if.master     imem,
   output logic [15:0] Instr,
   output logic [15:0] PC_Plus2,
   output logic        InstrValid,
   output logic        Halted,
   output logic [15:0] StallCycles
);

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] addr_q, addr_d;
   logic        squash_q, squash_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pc_plus2_q, pc_plus2_d;
   logic        valid_q, valid_d;

   logic [15:0] imem_addr, addr_plus2;
   logic        imem_rd, redirect_en, data_ok, capture, is_halt;
   logic        skid_wr, skid_rd, skid_clr, skid_full;
   logic [15:0] skid_data, skid_pc_plus2;

   cla_16b u_pc_add (
      .a_i   (imem_addr),
      .b_i   (16'd2),
      .cin_i (1'b0),
      .sum_o (addr_plus2)
   );

   fetch_skid u_skid (
      .clk        (clk),
      .rst        (rst),
      .wr_i       (skid_wr),
      .rd_i       (skid_rd),
      .clr_i      (skid_clr),
      .data_i     (imem.IMemData),
      .pc_plus2_i (addr_plus2),
      .full_o     (skid_full),
      .data_o     (skid_data),
      .pc_plus2_o (skid_pc_plus2)
   );

   // A full skid blocks new requests so it can never be overwritten.
   always_comb begin
      imem_addr = (state_q == StWait) ? addr_q : pc_q;
      imem_rd   = 1'b0;
      unique case (state_q)
         StReq:   imem_rd = !Stall && !skid_full;
         StWait:  imem_rd = 1'b1;
         default: imem_rd = 1'b0;
      endcase
      if (rst) imem_rd = 1'b0;
   end

   assign redirect_en = Redirect && (state_q != StHalt);
   assign data_ok     = imem_rd && imem.IMemDone && !squash_q;
   assign capture     = data_ok && !Stall && !redirect_en;
   assign skid_wr     = data_ok && Stall && !redirect_en;
   assign is_halt     = imem.IMemData[15:11] == OPC_HALT;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      squash_d   = squash_q;
      instr_d    = instr_q;
      pc_plus2_d = pc_plus2_q;
      valid_d    = valid_q;
      skid_rd    = 1'b0;
      skid_clr   = 1'b0;

      unique case (state_q)
         StReq: begin
            if (imem_rd && !imem.IMemDone) begin
               state_d = StWait;
               addr_d  = pc_q;
            end
         end
         StWait: begin
            if (imem.IMemDone) begin
               state_d  = StReq;
               squash_d = 1'b0;
            end
         end
         default: ;
      endcase

      if (capture || skid_wr) begin
         pc_d = addr_plus2;
         if (is_halt) state_d = StHalt;
      end

      if (redirect_en) begin
         pc_d     = PC_Next;
         valid_d  = 1'b0;
         instr_d  = NOP_INSTR;
         skid_clr = 1'b1;
         // Data for the abandoned address still has to be absorbed.
         if (imem_rd && !imem.IMemDone) squash_d = 1'b1;
      end else if (capture) begin
         instr_d    = imem.IMemData;
         pc_plus2_d = addr_plus2;
         valid_d    = 1'b1;
      end else if (!Stall) begin
         if (skid_full) begin
            instr_d    = skid_data;
            pc_plus2_d = skid_pc_plus2;
            valid_d    = 1'b1;
            skid_rd    = 1'b1;
         end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StReq;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         squash_q   <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc_plus2_q <= 16'h0000;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         squash_q   <= squash_d;
         instr_q    <= instr_d;
         pc_plus2_q <= pc_plus2_d;
         valid_q    <= valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 16'h0000;
      end else if (imem_rd && !imem.IMemDone && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign StallCycles = stall_cnt_q;
`else
   assign StallCycles = 16'h0000;
`endif

   assign imem.IMemAddr = imem_addr;
   assign imem.IMemRd   = imem_rd;
   assign Instr         = instr_q;
   assign PC_Plus2      = pc_plus2_q;
   assign InstrValid    = valid_q;
   assign Halted        = (state_q == StHalt);

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: variable-latency memory, transaction-level reference model
// compared every cycle, plus hand-computed spot checks.
module tb_fetch;

   localparam logic [15:0] RST_PC = 16'h0000;
   localparam logic [15:0] NOP    = 16'h0800;

   logic        clk;
   logic        rst;
   logic        Stall;
   logic        Redirect;
   logic [15:0] PC_Next;
   logic [15:0] Instr;
   logic [15:0] PC_Plus2;
   logic        InstrValid;
   logic        Halted;
   logic [15:0] StallCycles;

   int n_checks = 0;
   int n_errors = 0;
   int mem_lat  = 0;
   int wcnt     = 0;

   fetch_if imem_bus ();

   fetch #(
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .PC_Next     (PC_Next),
      .Redirect    (Redirect),
      .Stall       (Stall),
      .imem        (imem_bus),
      .Instr       (Instr),
      .PC_Plus2    (PC_Plus2),
      .InstrValid  (InstrValid),
      .Halted      (Halted),
      .StallCycles (StallCycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory image: 0x0008 holds 0x1234, 0x000A holds HALT, everything else 0x4000+addr/2.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0008: return 16'h1234;
         16'h000A: return 16'h0000;
         default:  return 16'h4000 + {1'b0, a[15:1]};
      endcase
   endfunction

   always @(posedge clk) wcnt <= (imem_bus.IMemRd && !imem_bus.IMemDone) ? wcnt + 1 : 0;
   assign imem_bus.IMemDone = imem_bus.IMemRd && (wcnt >= mem_lat);
   assign imem_bus.IMemData = imem_bus.IMemDone ? mem_word(imem_bus.IMemAddr) : 16'hDEAD;

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   // Reference model: request outstanding or not, squash flag, skid as a queue.
   logic        m_live   = 1'b0;
   logic [15:0] m_pc     = 16'h0000;
   logic        m_busy   = 1'b0;
   logic [15:0] m_addr   = 16'h0000;
   logic        m_squash = 1'b0;
   logic        m_halted = 1'b0;
   logic        m_valid  = 1'b0;
   logic [15:0] m_instr  = 16'h0800;
   logic [15:0] m_pc2    = 16'h0000;
   logic [15:0] m_cnt    = 16'h0000;
   logic [31:0] m_skq[$];

   always @(negedge clk) begin : cmp
      logic        e_rd, done, cap;
      logic [15:0] e_addr, w;
      logic [31:0] ent;
      if (m_live) begin
         chk1("instr_valid", InstrValid, m_valid);
         chk16("instr", Instr, m_instr);
         if (m_valid) chk16("pc_plus2", PC_Plus2, m_pc2);
         chk1("halted", Halted, m_halted);
         chk16("stall_cycles", StallCycles, m_cnt);
      end
      e_rd   = !rst && !m_halted && (m_busy || (!Stall && m_skq.size() == 0));
      e_addr = m_busy ? m_addr : m_pc;
      if (m_live) begin
         chk1("imem_rd", imem_bus.IMemRd, e_rd);
         if (e_rd) chk16("imem_addr", imem_bus.IMemAddr, e_addr);
      end
      done = e_rd && imem_bus.IMemDone;
      if (rst) begin
         m_live = 1'b1; m_pc = RST_PC; m_busy = 1'b0; m_squash = 1'b0; m_halted = 1'b0;
         m_valid = 1'b0; m_instr = NOP; m_pc2 = 16'h0000; m_cnt = 16'h0000;
         m_skq.delete();
      end else begin
`ifdef FETCH_PERF_CNT_EN
         if (e_rd && !imem_bus.IMemDone && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
         cap = 1'b0;
         if (!m_halted && Redirect) begin
            m_pc = PC_Next; m_valid = 1'b0; m_instr = NOP; m_skq.delete();
            m_busy   = e_rd && !imem_bus.IMemDone;
            m_squash = m_busy;
            if (m_busy) m_addr = e_addr;
         end else begin
            if (done) begin
               m_busy = 1'b0;
               if (m_squash) begin
                  m_squash = 1'b0;
               end else begin
                  w    = mem_word(e_addr);
                  m_pc = e_addr + 16'd2;
                  if (w[15:11] == 5'b00000) m_halted = 1'b1;
                  if (Stall) begin
                     m_skq.push_back({w, m_pc});
                  end else begin
                     cap = 1'b1; m_valid = 1'b1; m_instr = w; m_pc2 = m_pc;
                  end
               end
            end else if (e_rd) begin
               m_busy = 1'b1;
               m_addr = e_addr;
            end
            if (!cap && !Stall) begin
               if (m_skq.size() > 0) begin
                  ent = m_skq.pop_front();
                  m_instr = ent[31:16]; m_pc2 = ent[15:0]; m_valid = 1'b1;
               end else begin
                  m_valid = 1'b0; m_instr = NOP;
               end
            end
         end
      end
   end

   task automatic set(input logic r, input logic s, input logic re, input logic [15:0] n);
      rst = r; Stall = s; Redirect = re; PC_Next = n;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic r, input logic s, input logic re, input logic [15:0] n);
      set(r, s, re, n);
      tick();
   endtask

   initial begin
      set(1'b1, 1'b0, 1'b0, 16'h0000);
      repeat (2) @(posedge clk);
      #1;
      chk16("rst_instr", Instr, 16'h0800);
      chk1("rst_valid", InstrValid, 1'b0);
      chk16("rst_pc_plus2", PC_Plus2, 16'h0000);
      chk1("rst_halted", Halted, 1'b0);
      chk16("rst_stall_cycles", StallCycles, 16'h0000);
      chk1("rst_rd_low", imem_bus.IMemRd, 1'b0);

      // Zero-latency memory: one instruction per cycle.
      set(1'b0, 1'b0, 1'b0, 16'h0000);
      #1;
      chk1("z_rd", imem_bus.IMemRd, 1'b1);
      chk16("z_addr0", imem_bus.IMemAddr, 16'h0000);
      tick();
      chk16("z_instr0", Instr, 16'h4000);
      chk16("z_pc2_0", PC_Plus2, 16'h0002);
      chk1("z_valid0", InstrValid, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      chk16("z_instr1", Instr, 16'h4001);
      chk16("z_pc2_1", PC_Plus2, 16'h0004);
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      chk16("z_instr2", Instr, 16'h4002);
      chk16("z_pc2_2", PC_Plus2, 16'h0006);

      // Done on the third cycle of the request.
      mem_lat = 2;
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      chk1("w_valid_b0", InstrValid, 1'b0);
      chk16("w_instr_b0", Instr, 16'h0800);
      set(1'b0, 1'b0, 1'b0, 16'h0000);
      #1;
      chk16("w_addr_held", imem_bus.IMemAddr, 16'h0006);
      tick();
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      chk16("w_instr", Instr, 16'h4003);
      chk16("w_pc2", PC_Plus2, 16'h0008);
`ifdef FETCH_PERF_CNT_EN
      chk16("w_stall_cycles", StallCycles, 16'd2);
`else
      chk16("w_stall_cycles", StallCycles, 16'd0);
`endif

      // Stall on the Done cycle: data parks in the skid until Stall drops.
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      chk1("s_hold_valid", InstrValid, 1'b0);
      chk16("s_hold_instr", Instr, 16'h0800);
      cyc(1'b0, 1'b1, 1'b0, 16'h0000);
      set(1'b0, 1'b0, 1'b0, 16'h0000);
      #1;
      chk1("s_no_req_full", imem_bus.IMemRd, 1'b0);
      tick();
      chk16("s_instr", Instr, 16'h1234);
      chk1("s_valid", InstrValid, 1'b1);
      chk16("s_pc2", PC_Plus2, 16'h000A);

      // Redirect while the request to 0x0006 is outstanding.
      cyc(1'b0, 1'b1, 1'b1, 16'h0006);
      chk1("r_valid_flush", InstrValid, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      cyc(1'b0, 1'b0, 1'b1, 16'h0100);
      set(1'b0, 1'b0, 1'b0, 16'h0000);
      #1;
      chk16("r_old_addr", imem_bus.IMemAddr, 16'h0006);
      chk1("r_old_done", imem_bus.IMemDone, 1'b1);
      tick();
      chk1("r_discard", InstrValid, 1'b0);
      mem_lat = 0;
      set(1'b0, 1'b0, 1'b0, 16'h0000);
      #1;
      chk16("r_new_addr", imem_bus.IMemAddr, 16'h0100);
      tick();
      chk16("r_instr", Instr, 16'h4080);
      chk16("r_pc2", PC_Plus2, 16'h0102);

      // PC wrap at the top of the address space.
      cyc(1'b0, 1'b1, 1'b1, 16'hFFFE);
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      chk16("wrap_instr", Instr, 16'hBFFF);
      chk16("wrap_pc2", PC_Plus2, 16'h0000);
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      chk16("wrap_next_instr", Instr, 16'h4000);
      chk16("wrap_next_pc2", PC_Plus2, 16'h0002);

      // Sequential run into the HALT at 0x000A.
      repeat (4) cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      chk16("h_pre_instr", Instr, 16'h1234);
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      chk16("h_instr", Instr, 16'h0000);
      chk1("h_valid", InstrValid, 1'b1);
      chk16("h_pc2", PC_Plus2, 16'h000C);
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      chk1("h_halted", Halted, 1'b1);
      chk1("h_valid_once", InstrValid, 1'b0);
      set(1'b0, 1'b0, 1'b1, 16'h0200);
      #1;
      chk1("h_rd_off", imem_bus.IMemRd, 1'b0);
      tick();
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      chk1("h_redirect_ignored", Halted, 1'b1);
      chk1("h_rd_still_off", imem_bus.IMemRd, 1'b0);

      // Reset leaves HALT and restarts at RESET_PC.
      cyc(1'b1, 1'b0, 1'b0, 16'h0000);
      chk1("x_halted", Halted, 1'b0);
      set(1'b0, 1'b0, 1'b0, 16'h0000);
      #1;
      chk1("x_rd", imem_bus.IMemRd, 1'b1);
      chk16("x_addr", imem_bus.IMemAddr, 16'h0000);
      tick();
      chk16("x_instr", Instr, 16'h4000);
      cyc(1'b0, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
